// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause encoding,
// and the counter-width helper used to size the debounce/stretch/delay counters.
package rst_seq_pkg;

  localparam int unsigned CauseW = 2;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_PERIPH    = 2'd2,
    ST_RUN       = 2'd3
  } rst_seq_state_e;

  typedef enum logic [CauseW-1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_PLL  = 2'd1,
    CAUSE_BTN  = 2'd2,
    CAUSE_SOFT = 2'd3
  } rst_cause_e;

  // One spare bit above $clog2 so a counter can hold its terminal value without wrapping.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Reset-sequencer signal bundle.
//   pll_locked_i  : PLL lock, asynchronous
//   btn_rst_i     : raw reset push-button, asynchronous, bouncing
//   sw_rst_req_i  : single-cycle synchronous soft-reset request
//   rst_periph_no : active-low peripheral/bus reset
//   rst_core_no   : active-low CPU core reset
//   rst_cause_o   : cause of last reset (POR/PLL/button/soft)
//   busy_o        : high while any reset output is asserted
// master = the sequencer, slave = the surrounding system.
interface rst_seq_if;
  import rst_seq_pkg::*;

  logic              pll_locked_i;
  logic              btn_rst_i;
  logic              sw_rst_req_i;
  logic              rst_periph_no;
  logic              rst_core_no;
  logic [CauseW-1:0] rst_cause_o;
  logic              busy_o;

  modport master (
    input  pll_locked_i, btn_rst_i, sw_rst_req_i,
    output rst_periph_no, rst_core_no, rst_cause_o, busy_o
  );

  modport slave (
    output pll_locked_i, btn_rst_i, sw_rst_req_i,
    input  rst_periph_no, rst_core_no, rst_cause_o, busy_o
  );
endinterface

// File: rtl/rst_seq_sync.sv
// Two-flop synchronizer for asynchronous level inputs; 2-cycle latency.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages to 0
//   d   : asynchronous input
//   q   : synchronized output
module rst_seq_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: waits for PLL lock, stretches a full reset, releases the
// peripheral reset, then the core reset after a further delay. Lock loss,
// a debounced button press or a soft request re-enter the sequence.
//   clk_sys_i : system clock
//   rst_sys_i : asynchronous active-high power-on/board reset
//   bus       : rst_seq_if.master (lock/button/soft inputs, reset/cause/busy outputs)
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned DebounceCycles  = 1000,
  parameter int unsigned StretchCycles   = 16,
  parameter int unsigned CoreDelayCycles = 8
) (
  input  logic      clk_sys_i,
  input  logic      rst_sys_i,
  rst_seq_if.master bus
);

  localparam int unsigned DbW   = cnt_width(DebounceCycles);
  localparam int unsigned HoldW = cnt_width(StretchCycles);
  localparam int unsigned CoreW = cnt_width(CoreDelayCycles);

  localparam logic [DbW-1:0]   DbMax    = DbW'(DebounceCycles);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(StretchCycles - 1);
  localparam logic [CoreW-1:0] CoreLoad = CoreW'(CoreDelayCycles - 1);

  logic lock_s;
  logic btn_s;

  // Bring the asynchronous lock and button into the clk_sys_i domain.
  rst_seq_sync #(.Width(1)) u_sync_lock (
    .clk (clk_sys_i),
    .rst (rst_sys_i),
    .d   (bus.pll_locked_i),
    .q   (lock_s)
  );

  rst_seq_sync #(.Width(1)) u_sync_btn (
    .clk (clk_sys_i),
    .rst (rst_sys_i),
    .d   (bus.btn_rst_i),
    .q   (btn_s)
  );

  // Debounce: count consecutive high cycles, saturate at DebounceCycles.
  logic [DbW-1:0] db_cnt;
  logic           btn_press;

  assign btn_press = (db_cnt == DbMax);

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      db_cnt <= '0;
    end else if (!btn_s) begin
      db_cnt <= '0;
    end else if (!btn_press) begin
      db_cnt <= db_cnt + DbW'(1);
    end
  end

  rst_seq_state_e   state,    state_nxt;
  rst_cause_e       cause,    cause_nxt;
  logic [HoldW-1:0] hold_cnt, hold_nxt;
  logic [CoreW-1:0] core_cnt, core_nxt;
  logic             periph_n, core_n, busy;

  // Next-state decode; events are prioritised lock loss > button > soft request.
  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    hold_nxt  = hold_cnt;
    core_nxt  = core_cnt;

    if (!lock_s) begin
      state_nxt = ST_WAIT_LOCK;
      // Staying in WAIT_LOCK (e.g. power-up) is not a new event.
      if (state != ST_WAIT_LOCK) begin
        cause_nxt = CAUSE_PLL;
      end
    end else if (btn_press) begin
      state_nxt = ST_HOLD;
      hold_nxt  = HoldLoad;
      cause_nxt = CAUSE_BTN;
    end else if (bus.sw_rst_req_i && (state != ST_WAIT_LOCK)) begin
      state_nxt = ST_HOLD;
      hold_nxt  = HoldLoad;
      cause_nxt = CAUSE_SOFT;
    end else begin
      case (state)
        ST_WAIT_LOCK: begin
          state_nxt = ST_HOLD;
          hold_nxt  = HoldLoad;
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            state_nxt = ST_PERIPH;
            core_nxt  = CoreLoad;
          end else begin
            hold_nxt = hold_cnt - HoldW'(1);
          end
        end
        ST_PERIPH: begin
          if (core_cnt == '0) begin
            state_nxt = ST_RUN;
          end else begin
            core_nxt = core_cnt - CoreW'(1);
          end
        end
        ST_RUN: begin
          state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  // State and outputs load together from the next-state decode, so outputs
  // come straight off flops and change in the same cycle as the state.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state    <= ST_WAIT_LOCK;
      cause    <= CAUSE_POR;
      hold_cnt <= '0;
      core_cnt <= '0;
      periph_n <= 1'b0;
      core_n   <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= state_nxt;
      cause    <= cause_nxt;
      hold_cnt <= hold_nxt;
      core_cnt <= core_nxt;
      periph_n <= (state_nxt == ST_PERIPH) || (state_nxt == ST_RUN);
      core_n   <= (state_nxt == ST_RUN);
      busy     <= (state_nxt != ST_RUN);
    end
  end

  assign bus.rst_periph_no = periph_n;
  assign bus.rst_core_no   = core_n;
  assign bus.rst_cause_o   = cause;
  assign bus.busy_o        = busy;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq (DebounceCycles=4, StretchCycles=16, CoreDelayCycles=8).
// Stimulus pushes each expected output change {cycle, periph_n, core_n, cause, busy}
// into a queue; a negedge monitor pops an entry whenever the output tuple changes.
module tb_rst_seq;
  import rst_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rst_seq_if bus ();

  rst_seq #(
    .DebounceCycles  (4),
    .StretchCycles   (16),
    .CoreDelayCycles (8)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .bus       (bus)
  );

  typedef struct {
    int         cyc;
    logic [4:0] val;
    string      tag;
  } ev_t;

  ev_t sbq[$];

  function automatic void exp_push(input int cy, input logic p, input logic c,
                                   input logic [1:0] ca, input logic b, input string tag);
    ev_t e;
    e.cyc = cy;
    e.val = {p, c, ca, b};
    e.tag = tag;
    sbq.push_back(e);
  endfunction

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_sw();
    bus.sw_rst_req_i = 1'b1;
    @(negedge clk);
    bus.sw_rst_req_i = 1'b0;
  endtask

  // Monitor: every change of the output tuple must match the next expected event.
  logic [4:0] prev;
  logic       first = 1'b1;
  always @(negedge clk) begin
    logic [4:0] cur;
    ev_t e;
    cur = {bus.rst_periph_no, bus.rst_core_no, bus.rst_cause_o, bus.busy_o};
    if (first || (cur != prev)) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cyc=%0d got=%b, required no change (prev=%b)",
                 cyc, cur, prev);
      end else begin
        e = sbq.pop_front();
        if ((e.cyc != cyc) || (cur != e.val)) begin
          errors++;
          $display("FAIL %s: got cyc=%0d val=%b, required cyc=%0d val=%b",
                   e.tag, cyc, cur, e.cyc, e.val);
        end
      end
      prev  = cur;
      first = 1'b0;
    end
  end

  initial begin
    int c;
    int c2;
    rst                  = 1'b0;
    bus.pll_locked_i     = 1'b1;
    bus.btn_rst_i        = 1'b0;
    bus.sw_rst_req_i     = 1'b0;
    exp_push(1, 1'b0, 1'b0, 2'd0, 1'b1, "reset_state");
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Power-up release with lock already high.
    c = cyc;
    rst = 1'b0;
    exp_push(c + 19, 1'b1, 1'b0, 2'd0, 1'b1, "por_periph_rel");
    exp_push(c + 27, 1'b1, 1'b1, 2'd0, 1'b0, "por_core_rel");
    wait_to(c + 30);

    // Lock dropped for 3 cycles.
    c = cyc;
    bus.pll_locked_i = 1'b0;
    exp_push(c + 3,  1'b0, 1'b0, 2'd1, 1'b1, "pll_loss");
    exp_push(c + 22, 1'b1, 1'b0, 2'd1, 1'b1, "pll_periph_rel");
    exp_push(c + 30, 1'b1, 1'b1, 2'd1, 1'b0, "pll_core_rel");
    wait_to(c + 3);
    bus.pll_locked_i = 1'b1;
    wait_to(c + 35);

    // Short button bounce (3 cycles): no reset.
    c = cyc;
    bus.btn_rst_i = 1'b1;
    wait_to(c + 3);
    bus.btn_rst_i = 1'b0;
    wait_to(c + 12);

    // Button held 6 cycles: saturates the debouncer and holds HOLD.
    c = cyc;
    bus.btn_rst_i = 1'b1;
    exp_push(c + 7,  1'b0, 1'b0, 2'd2, 1'b1, "btn_hold");
    exp_push(c + 25, 1'b1, 1'b0, 2'd2, 1'b1, "btn_periph_rel");
    exp_push(c + 33, 1'b1, 1'b1, 2'd2, 1'b0, "btn_core_rel");
    wait_to(c + 6);
    bus.btn_rst_i = 1'b0;
    wait_to(c + 40);

    // Soft request in RUN, then again 5 cycles into PERIPH.
    c = cyc;
    exp_push(c + 1,  1'b0, 1'b0, 2'd3, 1'b1, "soft_hold");
    exp_push(c + 17, 1'b1, 1'b0, 2'd3, 1'b1, "soft_periph_rel");
    exp_push(c + 22, 1'b0, 1'b0, 2'd3, 1'b1, "soft_restart");
    exp_push(c + 38, 1'b1, 1'b0, 2'd3, 1'b1, "soft_periph_rel2");
    exp_push(c + 46, 1'b1, 1'b1, 2'd3, 1'b0, "soft_core_rel");
    pulse_sw();
    wait_to(c + 21);
    pulse_sw();
    wait_to(c + 50);

    // Lock loss, button press and soft request all seen by the FSM on one edge.
    c = cyc;
    bus.btn_rst_i = 1'b1;
    exp_push(c + 7,  1'b0, 1'b0, 2'd1, 1'b1, "combo_pll_wins");
    exp_push(c + 29, 1'b1, 1'b0, 2'd1, 1'b1, "combo_periph_rel");
    exp_push(c + 37, 1'b1, 1'b1, 2'd1, 1'b0, "combo_core_rel");
    wait_to(c + 4);
    bus.pll_locked_i = 1'b0;
    wait_to(c + 6);
    bus.sw_rst_req_i = 1'b1;
    wait_to(c + 7);
    bus.sw_rst_req_i = 1'b0;
    bus.btn_rst_i    = 1'b0;
    wait_to(c + 10);
    bus.pll_locked_i = 1'b1;
    wait_to(c + 42);

    // Board reset asserted mid-PERIPH takes effect without a clock edge.
    c = cyc;
    exp_push(c + 1,  1'b0, 1'b0, 2'd3, 1'b1, "pre_hold");
    exp_push(c + 17, 1'b1, 1'b0, 2'd3, 1'b1, "pre_periph_rel");
    exp_push(c + 21, 1'b0, 1'b0, 2'd0, 1'b1, "async_rst_sb");
    pulse_sw();
    wait_to(c + 20);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.rst_periph_no, bus.rst_core_no, bus.rst_cause_o, bus.busy_o} != 5'b00001) begin
      errors++;
      $display("FAIL async_rst_immediate: got=%b, required=%b",
               {bus.rst_periph_no, bus.rst_core_no, bus.rst_cause_o, bus.busy_o}, 5'b00001);
    end
    wait_to(c + 22);
    rst = 1'b0;
    c2 = cyc;
    exp_push(c2 + 19, 1'b1, 1'b0, 2'd0, 1'b1, "rerel_periph");
    exp_push(c2 + 27, 1'b1, 1'b1, 2'd0, 1'b0, "rerel_core");
    wait_to(c2 + 32);

    // Soft request while in WAIT_LOCK on the edge lock returns: ignored, cause stays PLL.
    c = cyc;
    bus.pll_locked_i = 1'b0;
    exp_push(c + 3,  1'b0, 1'b0, 2'd1, 1'b1, "wl_drop");
    exp_push(c + 23, 1'b1, 1'b0, 2'd1, 1'b1, "wl_periph_rel");
    exp_push(c + 31, 1'b1, 1'b1, 2'd1, 1'b0, "wl_core_rel");
    wait_to(c + 4);
    bus.pll_locked_i = 1'b1;
    wait_to(c + 6);
    bus.sw_rst_req_i = 1'b1;
    wait_to(c + 7);
    bus.sw_rst_req_i = 1'b0;
    wait_to(c + 36);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending, required 0 (next %s at cyc %0d)",
               sbq.size(), sbq[0].tag, sbq[0].cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
